// File: rtl/rcvbuf.sv
// 8N1 serial receiver with one-byte holding register: ready rises 1 cycle after the stop-bit sample.
// No backpressure on the line; a frame completing while the register is still full is dropped and flags overrun.
module rcvbuf #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read,
    input  logic       serial_in,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    sync;
    logic          rx;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          done;
    logic          half_hit;
    logic          full_hit;
    logic          timer_clr;
    logic          idx_clr;
    logic          shift_en;
    logic          frame_ok;
    logic          eff_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], serial_in};
        end
    end

    assign rx       = sync[1];
    assign half_hit = (timer == HALF_M1);
    assign full_hit = (timer == FULL_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!rx) state_nxt = S_START;
            S_START:     if (half_hit) state_nxt = rx ? S_IDLE : S_DATA;
            S_DATA:      if (full_hit && idx == 3'd7) state_nxt = S_STOP;
            S_STOP:      if (full_hit) state_nxt = rx ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // The timer is held at zero outside the timed states, so IDLE exit starts a fresh count.
    always_comb begin
        timer_clr = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        case (state)
            S_IDLE:      timer_clr = 1'b1;
            S_START: begin
                timer_clr = half_hit;
                idx_clr   = half_hit;
            end
            S_DATA: begin
                timer_clr = full_hit;
                shift_en  = full_hit;
            end
            S_STOP: begin
                timer_clr = full_hit;
                frame_ok  = full_hit & rx;
            end
            S_WAIT_IDLE: timer_clr = 1'b1;
            default:     timer_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            idx   <= 3'd0;
            shift <= 8'h00;
            done  <= 1'b0;
        end else begin
            timer <= timer_clr ? '0 : timer + TW'(1);
            if (idx_clr) begin
                idx <= 3'd0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {rx, shift[7:1]};
            end
            done <= frame_ok;
        end
    end

    assign eff_read = read & ready;

    // A read in the same cycle as done frees the slot, so the new byte is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            data_out <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            if (done) begin
                if (!ready || read) begin
                    data_out <= shift;
                    ready    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (eff_read) begin
                ready <= 1'b0;
            end
            if (eff_read) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rcvbuf.sv
// Randomised and directed bench for rcvbuf; a frame-level model predicts holding-register contents each cycle.
module tb_rcvbuf;

    localparam int CPB = 8;
    // line fall edge -> 2 synchroniser cycles -> start/data/stop sampling -> register update one cycle later
    localparam int DONE_OFS = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       read = 1'b0;
    logic       serial_in = 1'b1;
    logic       ready;
    logic       overrun;
    logic [7:0] data_out;

    int         edge_n = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    int         rd_mode = 0;   // 0 none, 1 read as ready rises, 2 random
    logic [7:0] sched [int];   // edge number -> byte that lands in the holding register then
    bit         force_rd [int];
    logic       m_ready = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_dat = 8'h00;

    rcvbuf #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .serial_in (serial_in),
        .ready     (ready),
        .data_out  (data_out),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Model: apply the holding-register rules at each edge, then compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
                m_dat   = 8'h00;
                sched.delete();
            end else begin
                logic eff;
                eff = read && m_ready;
                if (sched.exists(edge_n)) begin
                    if (!m_ready || eff) begin
                        m_dat   = sched[edge_n];
                        m_ready = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (eff) begin
                    m_ready = 1'b0;
                end
                if (eff) m_ovr = 1'b0;
            end
            #1;
            if (chk_en) begin
                check("model_ready", ready, m_ready);
                check("model_overrun", overrun, m_ovr);
                check("model_data", data_out, m_dat);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            read = force_rd.exists(edge_n + 1) ||
                   (rd_mode == 1 && m_ready) ||
                   (rd_mode == 2 && $urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at the negedge following the last driven bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int nbits);
        logic [9:0] fr;
        int n0;
        fr = {stop_ok, b, 1'b0};
        n0 = edge_n + 1;
        if (stop_ok && nbits == 10) sched[n0 + DONE_OFS] = b;
        for (int i = 0; i < nbits; i++) begin
            serial_in = fr[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        force_rd[edge_n + 2] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_data", data_out, 8'h00);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, 10);
        check("a5_ready", ready, 1'b1);
        check("a5_data", data_out, 8'hA5);
        check("a5_overrun", overrun, 1'b0);
        do_read();
        check("a5_read_ready", ready, 1'b0);
        check("a5_read_data", data_out, 8'hA5);
        idle(10);

        rd_mode = 1;
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        send_frame(8'h55, 1'b1, 10);
        idle(20);
        rd_mode = 0;
        check("b2b_data", data_out, 8'h55);
        check("b2b_ready", ready, 1'b0);
        check("b2b_overrun", overrun, 1'b0);

        send_frame(8'h12, 1'b1, 10);
        idle(5);
        send_frame(8'h34, 1'b1, 10);
        idle(5);
        check("ovr_data", data_out, 8'h12);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_ready", ready, 1'b1);
        do_read();
        check("ovr_read_ready", ready, 1'b0);
        check("ovr_read_flag", overrun, 1'b0);
        idle(5);

        send_frame(8'h11, 1'b1, 10);
        idle(3);
        force_rd[edge_n + 1 + DONE_OFS] = 1'b1;
        send_frame(8'h77, 1'b1, 10);
        check("simul_ready", ready, 1'b1);
        check("simul_data", data_out, 8'h77);
        check("simul_overrun", overrun, 1'b0);
        do_read();
        idle(5);

        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        check("glitch_ready", ready, 1'b0);

        send_frame(8'h3C, 1'b0, 10);
        repeat (200) @(negedge clk);
        check("break_ready", ready, 1'b0);
        idle(10);
        send_frame(8'h81, 1'b1, 10);
        check("resync_ready", ready, 1'b1);
        check("resync_data", data_out, 8'h81);
        do_read();
        idle(5);

        send_frame(8'h99, 1'b1, 10);
        idle(3);
        send_frame(8'hC3, 1'b1, 4);
        serial_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", ready, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_data", data_out, 8'h00);
        reset = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b1, 10);
        check("postrst_ready", ready, 1'b1);
        check("postrst_data", data_out, 8'h5A);
        do_read();
        idle(10);

        rd_mode = 2;
        for (int f = 0; f < 40; f++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send_frame(b, 1'b0, 10);
                repeat ($urandom_range(0, 30)) @(negedge clk);
                idle($urandom_range(6, 12));
            end else begin
                send_frame(b, 1'b1, 10);
                idle($urandom_range(0, 12));
            end
        end
        idle(20);
        rd_mode = 0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
